// File: rtl/ram_banked_dp_if.sv
// Request/response bundle between the core's LSU/fetch units and the banked RAM.
// The core drives the master side; the RAM implements the slave side.
interface ram_banked_dp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [NB-1:0]         i_req_be;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;
    logic                  i_fetch_valid;
    logic [ADDR_WIDTH-1:0] i_fetch_addr;
    logic                  o_fetch_valid;
    logic [DATA_WIDTH-1:0] o_fetch_data;
    logic                  o_fetch_err;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_be, i_req_wdata,
        output i_fetch_valid, i_fetch_addr,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_fetch_valid, o_fetch_data, o_fetch_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_be, i_req_wdata,
        input  i_fetch_valid, i_fetch_addr,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_fetch_valid, o_fetch_data, o_fetch_err
    );
endinterface

// File: rtl/ram_banked_dp.sv
// Byte-laned dual-port RAM: load/store data port plus fetch port, with error flags,
// store-to-fetch forwarding, selectable read latency and a post-reset zero scrub.
module ram_banked_dp #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter bit INIT_ZERO    = 1'b1,
    parameter bit FWD_EN       = 1'b1
) (
    input logic             clk,
    input logic             rst,
    input logic             clk_en,
    ram_banked_dp_if.slave  bus
);
    localparam int NB        = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NB);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int SPAN_BITS = LANE_BITS + IDX_BITS;

    typedef enum logic {SCRUB, RUN} state_t;

    state_t                state;
    logic [IDX_BITS-1:0]   scrub_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rsp_v1, rsp_err1, rsp_v2, rsp_err2;
    logic [DATA_WIDTH-1:0] rsp_d1, rsp_d2;
    logic                  fet_v1, fet_err1, fet_v2, fet_err2;
    logic [DATA_WIDTH-1:0] fet_d1, fet_d2;

    // Any address bit above the mapped span is an error rather than an alias.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return ((a & ADDR_WIDTH'(NB - 1)) != '0) || ((a >> SPAN_BITS) != '0);
    endfunction

    function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LANE_BITS +: IDX_BITS];
    endfunction

    logic                  run_en, scrub_wr, req_acc, fetch_acc, store_wr;
    logic                  req_err, fetch_err;
    logic [IDX_BITS-1:0]   req_idx, fetch_idx;
    logic [DATA_WIDTH-1:0] fetch_word;

    assign run_en    = rst && clk_en && (state == RUN);
    assign scrub_wr  = rst && clk_en && (state == SCRUB);
    assign req_acc   = bus.i_req_valid && run_en;
    assign fetch_acc = bus.i_fetch_valid && run_en;
    assign req_err   = addr_err(bus.i_req_addr);
    assign fetch_err = addr_err(bus.i_fetch_addr);
    assign req_idx   = word_idx(bus.i_req_addr);
    assign fetch_idx = word_idx(bus.i_fetch_addr);
    assign store_wr  = req_acc && bus.i_req_we && !req_err;

    assign bus.o_req_ready = run_en;

    // A fetch colliding with a same-cycle store sees the stored lanes merged over the old word.
    always_comb begin
        fetch_word = mem[fetch_idx];
        if (FWD_EN && store_wr && (fetch_idx == req_idx)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.i_req_be[i]) fetch_word[8*i +: 8] = bus.i_req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (scrub_wr) begin
            mem[scrub_cnt] <= '0;
        end else if (store_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.i_req_be[i]) mem[req_idx][8*i +: 8] <= bus.i_req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT_ZERO ? SCRUB : RUN;
            scrub_cnt <= '0;
            rsp_v1    <= 1'b0;
            rsp_err1  <= 1'b0;
            rsp_d1    <= '0;
            rsp_v2    <= 1'b0;
            rsp_err2  <= 1'b0;
            rsp_d2    <= '0;
            fet_v1    <= 1'b0;
            fet_err1  <= 1'b0;
            fet_d1    <= '0;
            fet_v2    <= 1'b0;
            fet_err2  <= 1'b0;
            fet_d2    <= '0;
        end else if (clk_en) begin
            case (state)
                SCRUB: begin
                    scrub_cnt <= scrub_cnt + 1'b1;
                    if (scrub_cnt == IDX_BITS'(DEPTH - 1)) state <= RUN;
                end
                default: state <= RUN;
            endcase
            rsp_v1   <= req_acc;
            rsp_err1 <= req_acc && req_err;
            rsp_d1   <= (req_acc && !bus.i_req_we && !req_err) ? mem[req_idx] : '0;
            fet_v1   <= fetch_acc;
            fet_err1 <= fetch_acc && fetch_err;
            fet_d1   <= (fetch_acc && !fetch_err) ? fetch_word : '0;
            rsp_v2   <= rsp_v1;
            rsp_err2 <= rsp_err1;
            rsp_d2   <= rsp_d1;
            fet_v2   <= fet_v1;
            fet_err2 <= fet_err1;
            fet_d2   <= fet_d1;
        end
    end

    assign bus.o_rsp_valid   = (READ_LATENCY == 2) ? rsp_v2   : rsp_v1;
    assign bus.o_rsp_err     = (READ_LATENCY == 2) ? rsp_err2 : rsp_err1;
    assign bus.o_rsp_rdata   = (READ_LATENCY == 2) ? rsp_d2   : rsp_d1;
    assign bus.o_fetch_valid = (READ_LATENCY == 2) ? fet_v2   : fet_v1;
    assign bus.o_fetch_err   = (READ_LATENCY == 2) ? fet_err2 : fet_err1;
    assign bus.o_fetch_data  = (READ_LATENCY == 2) ? fet_d2   : fet_d1;
endmodule

// File: tb/tb_ram_banked_dp.sv
// Directed bench: two RAMs share stimulus, A with latency 1 and forwarding, B with latency 2 and none.
module tb_ram_banked_dp;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clkEn = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [3:0]  reqBe = '0;
    logic [31:0] reqWdata = '0;
    logic        fetchValid = 1'b0;
    logic [31:0] fetchAddr = '0;

    int checkCount = 0;
    int passCount  = 0;

    ram_banked_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busA ();
    ram_banked_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busB ();

    assign busA.i_req_valid   = reqValid;
    assign busA.i_req_we      = reqWe;
    assign busA.i_req_addr    = reqAddr;
    assign busA.i_req_be      = reqBe;
    assign busA.i_req_wdata   = reqWdata;
    assign busA.i_fetch_valid = fetchValid;
    assign busA.i_fetch_addr  = fetchAddr;
    assign busB.i_req_valid   = reqValid;
    assign busB.i_req_we      = reqWe;
    assign busB.i_req_addr    = reqAddr;
    assign busB.i_req_be      = reqBe;
    assign busB.i_req_wdata   = reqWdata;
    assign busB.i_fetch_valid = fetchValid;
    assign busB.i_fetch_addr  = fetchAddr;

    ram_banked_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1),
                    .INIT_ZERO(1'b1), .FWD_EN(1'b1))
        dutA (.clk(clk), .rst(rst), .clk_en(clkEn), .bus(busA));

    ram_banked_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(2),
                    .INIT_ZERO(1'b1), .FWD_EN(1'b0))
        dutB (.clk(clk), .rst(rst), .clk_en(clkEn), .bus(busB));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic fv, input logic [31:0] faddr);
        reqValid   = rv;
        reqWe      = we;
        reqAddr    = addr;
        reqBe      = be;
        reqWdata   = wdata;
        fetchValid = fv;
        fetchAddr  = faddr;
        tick();
        reqValid   = 1'b0;
        fetchValid = 1'b0;
    endtask

    // Called right after the accept edge: A answers now, B one cycle later.
    task automatic expectRsp(input string tag, input logic isFetch, input logic [31:0] dataA,
                             input logic [31:0] dataB, input logic errExp);
        checkOutput({tag, "/validA"}, isFetch ? busA.o_fetch_valid : busA.o_rsp_valid, 32'd1);
        checkOutput({tag, "/dataA"},  isFetch ? busA.o_fetch_data  : busA.o_rsp_rdata, dataA);
        checkOutput({tag, "/errA"},   isFetch ? busA.o_fetch_err   : busA.o_rsp_err,   {31'd0, errExp});
        tick();
        checkOutput({tag, "/validA_off"}, isFetch ? busA.o_fetch_valid : busA.o_rsp_valid, 32'd0);
        checkOutput({tag, "/validB"}, isFetch ? busB.o_fetch_valid : busB.o_rsp_valid, 32'd1);
        checkOutput({tag, "/dataB"},  isFetch ? busB.o_fetch_data  : busB.o_rsp_rdata, dataB);
        checkOutput({tag, "/errB"},   isFetch ? busB.o_fetch_err   : busB.o_rsp_err,   {31'd0, errExp});
    endtask

    task automatic waitScrub(input string tag);
        int n = 0;
        while (!busA.o_req_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, "/cycles"}, n, DEPTH);
        checkOutput({tag, "/readyB"}, busB.o_req_ready, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        checkOutput("reset/readyA", busA.o_req_ready, 32'd0);
        checkOutput("reset/rspA", busA.o_rsp_valid, 32'd0);
        checkOutput("reset/fetchB", busB.o_fetch_valid, 32'd0);
        rst = 1'b1;
        waitScrub("scrub1");

        applyStimulus(1, 0, 32'h10, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load_scrubbed", 0, 32'h0, 32'h0, 0);

        applyStimulus(1, 1, 32'h40, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        expectRsp("store40", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load40", 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);

        applyStimulus(1, 1, 32'h40, 4'b0101, 32'h11223344, 0, 32'h0);
        expectRsp("store40_be", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load40_be", 0, 32'hDE22BE44, 32'hDE22BE44, 0);

        applyStimulus(1, 1, 32'h44, 4'hF, 32'hCAFEF00D, 0, 32'h0);
        checkOutput("b2b/storeA", busA.o_rsp_valid, 32'd1);
        applyStimulus(1, 0, 32'h44, 4'h0, 32'h0, 0, 32'h0);
        checkOutput("b2b/loadA", busA.o_rsp_rdata, 32'hCAFEF00D);
        checkOutput("b2b/storeB", busB.o_rsp_valid, 32'd1);
        tick();
        checkOutput("b2b/loadB", busB.o_rsp_rdata, 32'hCAFEF00D);

        applyStimulus(1, 0, 32'h42, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load_misaligned", 0, 32'h0, 32'h0, 1);
        applyStimulus(1, 1, 32'h100, 4'hF, 32'hFFFFFFFF, 0, 32'h0);
        expectRsp("store_range", 0, 32'h0, 32'h0, 1);
        applyStimulus(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load0_intact", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 1, 32'h10000040, 4'hF, 32'h0, 0, 32'h0);
        expectRsp("store_alias", 0, 32'h0, 32'h0, 1);
        applyStimulus(1, 1, 32'h41, 4'hF, 32'h0, 0, 32'h0);
        expectRsp("store_misaligned", 0, 32'h0, 32'h0, 1);
        applyStimulus(1, 1, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("store_be0", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load40_intact", 0, 32'hDE22BE44, 32'hDE22BE44, 0);
        applyStimulus(1, 0, 32'hFC, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load_lastword", 0, 32'h0, 32'h0, 0);

        applyStimulus(1, 1, 32'h80, 4'hF, 32'h01020304, 0, 32'h0);
        expectRsp("store80", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 1, 32'h80, 4'b0011, 32'hAABBCCDD, 1, 32'h80);
        expectRsp("fwd_fetch", 1, 32'h0102CCDD, 32'h01020304, 0);
        applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h80);
        expectRsp("fetch80", 1, 32'h0102CCDD, 32'h0102CCDD, 0);
        applyStimulus(1, 1, 32'h82, 4'hF, 32'h55555555, 1, 32'h80);
        expectRsp("no_fwd_err_store", 1, 32'h0102CCDD, 32'h0102CCDD, 0);
        applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h82);
        expectRsp("fetch_misaligned", 1, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h100);
        expectRsp("fetch_range", 1, 32'h0, 32'h0, 1);

        // Freeze with a load in flight; a store offered while frozen must not land.
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        clkEn    = 1'b0;
        reqValid = 1'b1;
        reqWe    = 1'b1;
        reqBe    = 4'hF;
        reqWdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall/validA", busA.o_rsp_valid, 32'd1);
            checkOutput("stall/dataA", busA.o_rsp_rdata, 32'hDE22BE44);
            checkOutput("stall/validB", busB.o_rsp_valid, 32'd0);
            checkOutput("stall/readyA", busA.o_req_ready, 32'd0);
        end
        reqValid = 1'b0;
        clkEn    = 1'b1;
        tick();
        checkOutput("resume/validA", busA.o_rsp_valid, 32'd0);
        checkOutput("resume/validB", busB.o_rsp_valid, 32'd1);
        checkOutput("resume/dataB", busB.o_rsp_rdata, 32'hDE22BE44);
        tick();
        checkOutput("resume/validB_off", busB.o_rsp_valid, 32'd0);
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load40_after_stall", 0, 32'hDE22BE44, 32'hDE22BE44, 0);

        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("flush/validA", busA.o_rsp_valid, 32'd0);
        checkOutput("flush/dataA", busA.o_rsp_rdata, 32'h0);
        checkOutput("flush/validB", busB.o_rsp_valid, 32'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h40);
        checkOutput("scrub_fetch/validA", busA.o_fetch_valid, 32'd0);
        checkOutput("scrub_fetch/readyA", busA.o_req_ready, 32'd0);
        repeat (8) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        waitScrub("scrub2");
        applyStimulus(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0);
        expectRsp("load40_rescrubbed", 0, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
